// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: sub-word store RMW, load align/extend.
// Optional misalignment trap via MEM_ALIGN_TRAP_EN.
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_memwrite,
  input  logic              req_load,
  input  logic [2:0]        req_memread,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              align_err
);

  typedef enum logic [1:0] {
    IDLE, RMW_RD, RMW_WR, LD_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] merge_q, merge_d;

  logic        is_st, is_sw, is_sh, is_ld;
  logic        ld_h, ld_b, ld_s;
  logic [1:0]  off;
  logic        trap;
  logic [31:0] merged, ext;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign mem_addr = {req_addr[ADDR_W-1:2], 2'b00};

  assign is_st = (req_memwrite != 2'b00);
  assign is_sw = (req_memwrite == 2'b11);
  assign is_sh = (req_memwrite == 2'b01);
  assign is_ld = req_load & ~is_st;

  assign ld_h = (req_memread == 3'b001) | (req_memread == 3'b010);
  assign ld_b = (req_memread == 3'b011) | (req_memread == 3'b100);
  assign ld_s = (req_memread == 3'b001) | (req_memread == 3'b011);

  // halfwords only ever sit at offset 0 or 2; bytes use the full offset
  assign off = (is_sh | (is_ld & ld_h)) ? {req_addr[1], 1'b0}
                                        : req_addr[1:0];

`ifdef MEM_ALIGN_TRAP_EN
  logic mis;
  assign mis = is_st ? ((is_sw & (req_addr[1:0] != 2'b00)) |
                        (is_sh & req_addr[0]))
                     : (is_ld & (((~ld_h & ~ld_b) &
                                  (req_addr[1:0] != 2'b00)) |
                                 (ld_h & req_addr[0])));
  assign trap = req_valid & mis;
`else
  assign trap = 1'b0;
`endif

  // lane merge of store data into the word read back from memory
  always_comb begin
    merged = mem_rdata;
    if (is_sh) begin
      if (off[1]) merged[15:0] = req_wdata[15:0];
      else        merged[31:16] = req_wdata[15:0];
    end else begin
      unique case (off)
        2'd0:    merged[31:24] = req_wdata[7:0];
        2'd1:    merged[23:16] = req_wdata[7:0];
        2'd2:    merged[15:8]  = req_wdata[7:0];
        default: merged[7:0]   = req_wdata[7:0];
      endcase
    end
  end

  // load lane select and sign/zero extension
  always_comb begin
    unique case (off)
      2'd0:    rbyte = mem_rdata[31:24];
      2'd1:    rbyte = mem_rdata[23:16];
      2'd2:    rbyte = mem_rdata[15:8];
      default: rbyte = mem_rdata[7:0];
    endcase
    rhalf = off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    ext   = mem_rdata;
    if (ld_h)      ext = {{16{ld_s & rhalf[15]}}, rhalf};
    else if (ld_b) ext = {{24{ld_s & rbyte[7]}}, rbyte};
  end

  // state and merge register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
    end
  end

  // next state and outputs
  always_comb begin
    state_d    = state_q;
    merge_d    = merge_q;
    mem_we     = 1'b0;
    mem_wdata  = req_wdata;
    stall      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    align_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (trap) begin
            align_err  = 1'b1;
            load_valid = is_ld;
          end else if (is_sw) begin
            mem_we = 1'b1;
          end else if (is_st) begin
            stall   = 1'b1;
            state_d = RMW_RD;
          end else if (req_load) begin
            stall   = 1'b1;
            state_d = LD_WAIT;
          end
        end
      end
      RMW_RD: begin
        stall   = 1'b1;
        merge_d = merged;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        mem_we    = 1'b1;
        mem_wdata = merge_q;
        state_d   = IDLE;
      end
      default: begin
        load_valid = 1'b1;
        load_data  = ext;
        state_d    = IDLE;
      end
    endcase
    if (rst) begin
      state_d    = IDLE;
      merge_d    = '0;
      mem_we     = 1'b0;
      stall      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      align_err  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl with a word-wide synchronous memory model.
// Covers MEM_ALIGN_TRAP_EN in both builds.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_memwrite;
  logic        req_load;
  logic [2:0]  req_memread;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        align_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_memwrite(req_memwrite), .req_load(req_load),
    .req_memread(req_memread), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .stall(stall),
    .load_data(load_data), .load_valid(load_valid),
    .align_err(align_err)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
  end

  typedef struct {
    logic [1:0]  mw;
    logic        ld;
    logic [2:0]  mr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        pre;
    logic [31:0] pval;
    int          cyc;
    logic        lv;
    logic [31:0] ldd;
    logic [31:0] word;
    int          we;
    int          err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b0;
    pre_we = 1'b1;
    pre_idx = a[7:2];
    pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int cyc, we_cnt, err_cnt;
    logic done, lv;
    logic [31:0] ld;
    cyc = 0; we_cnt = 0; err_cnt = 0;
    done = 1'b0; lv = 1'b0; ld = '0;
    if (v.pre) preload(v.addr, v.pval);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = v.addr;
    req_wdata = v.wd;
    req_memwrite = v.mw;
    req_load = v.ld;
    req_memread = v.mr;
    for (int i = 0; i < 8 && !done; i++) begin
      #1;
      cyc++;
      if (mem_we) we_cnt++;
      if (align_err) err_cnt++;
      if (!stall) begin
        done = 1'b1;
        lv = load_valid;
        ld = load_data;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL vec%0d timeout: stall still 1 after 8 cycles", n);
    end
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d cycles", n), cyc, v.cyc);
    chk($sformatf("vec%0d we_cnt", n), we_cnt, v.we);
    chk($sformatf("vec%0d align_err", n), err_cnt, v.err);
    chk($sformatf("vec%0d load_valid", n), {31'b0, lv}, {31'b0, v.lv});
    if (v.lv) chk($sformatf("vec%0d load_data", n), ld, v.ldd);
    chk($sformatf("vec%0d word", n), mem[v.addr[7:2]], v.word);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = 32'h0;
    req_wdata = '0;
    req_memwrite = 2'b00;
    req_load = 1'b0;
    req_memread = 3'b000;

    // mw ld mr addr wd pre pval cyc lv ldd word we err
    vq.push_back('{2'b10, 1'b0, 3'd0, 32'h11, 32'h000000AB, 1'b1,
                   32'h11223344, 3, 1'b0, 32'h0, 32'h11AB3344, 1, 0});
    vq.push_back('{2'b01, 1'b0, 3'd0, 32'h12, 32'h0000BEEF, 1'b1,
                   32'h11223344, 3, 1'b0, 32'h0, 32'h1122BEEF, 1, 0});
    vq.push_back('{2'b00, 1'b1, 3'd2, 32'h12, 32'h0, 1'b0,
                   32'h0, 2, 1'b1, 32'h0000BEEF, 32'h1122BEEF, 0, 0});
    vq.push_back('{2'b00, 1'b1, 3'd1, 32'h12, 32'h0, 1'b0,
                   32'h0, 2, 1'b1, 32'hFFFFBEEF, 32'h1122BEEF, 0, 0});
    vq.push_back('{2'b00, 1'b1, 3'd3, 32'h20, 32'h0, 1'b1,
                   32'h80FF7F01, 2, 1'b1, 32'hFFFFFF80, 32'h80FF7F01, 0, 0});
    vq.push_back('{2'b00, 1'b1, 3'd4, 32'h20, 32'h0, 1'b0,
                   32'h0, 2, 1'b1, 32'h00000080, 32'h80FF7F01, 0, 0});
    vq.push_back('{2'b00, 1'b1, 3'd3, 32'h23, 32'h0, 1'b0,
                   32'h0, 2, 1'b1, 32'h00000001, 32'h80FF7F01, 0, 0});
    vq.push_back('{2'b00, 1'b1, 3'd3, 32'h21, 32'h0, 1'b0,
                   32'h0, 2, 1'b1, 32'hFFFFFFFF, 32'h80FF7F01, 0, 0});
    vq.push_back('{2'b00, 1'b1, 3'd4, 32'h22, 32'h0, 1'b0,
                   32'h0, 2, 1'b1, 32'h0000007F, 32'h80FF7F01, 0, 0});
    vq.push_back('{2'b00, 1'b1, 3'd1, 32'h20, 32'h0, 1'b0,
                   32'h0, 2, 1'b1, 32'hFFFF80FF, 32'h80FF7F01, 0, 0});
    vq.push_back('{2'b00, 1'b1, 3'd2, 32'h22, 32'h0, 1'b0,
                   32'h0, 2, 1'b1, 32'h00007F01, 32'h80FF7F01, 0, 0});
    vq.push_back('{2'b00, 1'b1, 3'd0, 32'h20, 32'h0, 1'b0,
                   32'h0, 2, 1'b1, 32'h80FF7F01, 32'h80FF7F01, 0, 0});
    vq.push_back('{2'b00, 1'b1, 3'd5, 32'h20, 32'h0, 1'b0,
                   32'h0, 2, 1'b1, 32'h80FF7F01, 32'h80FF7F01, 0, 0});
    vq.push_back('{2'b11, 1'b0, 3'd0, 32'h30, 32'hDEADBEEF, 1'b0,
                   32'h0, 1, 1'b0, 32'h0, 32'hDEADBEEF, 1, 0});
    vq.push_back('{2'b00, 1'b1, 3'd0, 32'h30, 32'h0, 1'b0,
                   32'h0, 2, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0});
    vq.push_back('{2'b10, 1'b0, 3'd0, 32'h33, 32'h12345655, 1'b0,
                   32'h0, 3, 1'b0, 32'h0, 32'hDEADBE55, 1, 0});
    vq.push_back('{2'b10, 1'b0, 3'd0, 32'h30, 32'h000000C3, 1'b0,
                   32'h0, 3, 1'b0, 32'h0, 32'hC3ADBE55, 1, 0});
    vq.push_back('{2'b11, 1'b1, 3'd3, 32'h34, 32'hCAFEF00D, 1'b0,
                   32'h0, 1, 1'b0, 32'h0, 32'hCAFEF00D, 1, 0});
    vq.push_back('{2'b01, 1'b0, 3'd0, 32'h10, 32'h0000A5A5, 1'b0,
                   32'h0, 3, 1'b0, 32'h0, 32'hA5A5BEEF, 1, 0});
`ifdef MEM_ALIGN_TRAP_EN
    vq.push_back('{2'b00, 1'b1, 3'd0, 32'h13, 32'h0, 1'b0,
                   32'h0, 1, 1'b1, 32'h0, 32'hA5A5BEEF, 0, 1});
    vq.push_back('{2'b01, 1'b0, 3'd0, 32'h11, 32'h00005555, 1'b0,
                   32'h0, 1, 1'b0, 32'h0, 32'hA5A5BEEF, 0, 1});
    vq.push_back('{2'b11, 1'b0, 3'd0, 32'h31, 32'h01020304, 1'b0,
                   32'h0, 1, 1'b0, 32'h0, 32'hC3ADBE55, 0, 1});
    vq.push_back('{2'b10, 1'b0, 3'd0, 32'h11, 32'h00000077, 1'b0,
                   32'h0, 3, 1'b0, 32'h0, 32'hA577BEEF, 1, 0});
`else
    vq.push_back('{2'b00, 1'b1, 3'd0, 32'h23, 32'h0, 1'b0,
                   32'h0, 2, 1'b1, 32'h80FF7F01, 32'h80FF7F01, 0, 0});
    vq.push_back('{2'b00, 1'b1, 3'd1, 32'h23, 32'h0, 1'b0,
                   32'h0, 2, 1'b1, 32'h00007F01, 32'h80FF7F01, 0, 0});
    vq.push_back('{2'b00, 1'b1, 3'd2, 32'h21, 32'h0, 1'b0,
                   32'h0, 2, 1'b1, 32'h000080FF, 32'h80FF7F01, 0, 0});
    vq.push_back('{2'b01, 1'b0, 3'd0, 32'h13, 32'h00005555, 1'b0,
                   32'h0, 3, 1'b0, 32'h0, 32'hA5A55555, 1, 0});
    vq.push_back('{2'b11, 1'b0, 3'd0, 32'h31, 32'h01020304, 1'b0,
                   32'h0, 1, 1'b0, 32'h0, 32'h01020304, 1, 0});
`endif

    // reset state, including a sw presented while rst is high
    @(negedge clk);
    #1;
    chk("rst stall", {31'b0, stall}, 32'h0);
    chk("rst load_valid", {31'b0, load_valid}, 32'h0);
    chk("rst load_data", load_data, 32'h0);
    chk("rst align_err", {31'b0, align_err}, 32'h0);
    req_valid = 1'b1;
    req_memwrite = 2'b11;
    req_addr = 32'h3C;
    #1;
    chk("rst mem_we", {31'b0, mem_we}, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    req_memwrite = 2'b00;
    rst = 1'b0;
    req_addr = 32'h1237;
    #1;
    chk("idle stall", {31'b0, stall}, 32'h0);
    chk("idle mem_we", {31'b0, mem_we}, 32'h0);
    chk("idle mem_addr", mem_addr, 32'h00001234);

    foreach (vq[i]) run_vec(i, vq[i]);

    // reset while an sb sits in RMW_RD
    preload(32'h40, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 32'h41;
    req_wdata = 32'h000000AB;
    req_memwrite = 2'b10;
    req_load = 1'b0;
    #1;
    chk("rmw start stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rmw rst mem_we", {31'b0, mem_we}, 32'h0);
    chk("rmw rst stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post rst stall", {31'b0, stall}, 32'h0);
    chk("post rst mem_we", {31'b0, mem_we}, 32'h0);
    @(negedge clk);
    #1;
    chk("post rst mem_we2", {31'b0, mem_we}, 32'h0);
    @(posedge clk);
    #1;
    chk("rmw rst word", mem[16], 32'h11223344);
    run_vec(100, '{2'b10, 1'b0, 3'd0, 32'h42, 32'h000000CD, 1'b0,
                   32'h0, 3, 1'b0, 32'h0, 32'h1122CD44, 1, 0});

    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("final stall", {31'b0, stall}, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
